// File: rtl/cmult_pipe_pkg.sv
// cmult_pkg: mode encoding, saturation limits and round/shift helper shared by cmult_pipe
package cmult_pkg;
  typedef enum logic {REAL_PAIR = 1'b0, COMPLEX = 1'b1} mode_e;
  // Wide enough to hold any 2W+2 result plus rounding headroom for W up to 64
  localparam int MAXP = 160;
  typedef logic signed [MAXP-1:0] wide_t;
  localparam wide_t ONE = wide_t'(1);
  function automatic wide_t sat_max(input int w, input logic sgn);
    return sgn ? (ONE <<< (w - 1)) - ONE : (ONE <<< w) - ONE;
  endfunction
  function automatic wide_t sat_min(input int w, input logic sgn);
    return sgn ? -(ONE <<< (w - 1)) : '0;
  endfunction
  function automatic wide_t round_shift(input wide_t v, input int frac, input logic rnd);
    return (rnd ? v + (ONE <<< (frac - 1)) : v) >>> frac;
  endfunction
endpackage

// File: rtl/cmult_pipe_if.sv
// cmult_pipe_if: operand/result bus with valid/ready on both sides
interface cmult_pipe_if #(parameter int W = 32);
  logic in_valid, in_ready, in_complex, out_valid, out_ready;
  logic [W-1:0] real_a, im_a, real_b, im_b;
  logic [2*W-1:0] out;
  logic [1:0] out_ovf;
  modport master (
    output in_valid, in_complex, real_a, im_a, real_b, im_b, out_ready,
    input in_ready, out_valid, out, out_ovf
  );
  modport slave (
    input in_valid, in_complex, real_a, im_a, real_b, im_b, out_ready,
    output in_ready, out_valid, out, out_ovf
  );
endinterface

// File: rtl/cmult_round_sat.sv
// cmult_round_sat: scales one full-precision component to W bits with optional rounding and saturation
module cmult_round_sat import cmult_pkg::*; #(
  parameter int W = 32,
  parameter int FRAC = 32,
  parameter int SIGNED = 0,
  parameter int ROUND = 0,
  parameter int SAT = 0,
  parameter int P = 2 * W + 2
) (
  input  logic signed [P-1:0] full,
  output logic [W-1:0]        val,
  output logic                ovf
);
  wide_t sh, hi, lo;
  always_comb begin
    sh = round_shift({{(MAXP-P){full[P-1]}}, full}, FRAC, ROUND != 0);
    hi = sat_max(W, SIGNED != 0);
    lo = sat_min(W, SIGNED != 0);
    ovf = sh > hi || sh < lo;
    val = (SAT != 0 && ovf) ? (sh < lo ? lo[W-1:0] : hi[W-1:0]) : sh[W-1:0];
  end
endmodule

// File: rtl/cmult_pipe.sv
// cmult_pipe: pipelined complex / real-pair multiplier with fixed-point scaling and valid/ready flow control
module cmult_pipe import cmult_pkg::*; #(
  parameter int W = 32,
  parameter int FRAC = 32,
  parameter int SIGNED = 0,
  parameter int ROUND = 0,
  parameter int SAT = 0
) (
  input logic clock,
  input logic reset_n,
  cmult_pipe_if.slave bus
);
  localparam int P = 2 * W + 2;
  logic rdy, en, acc, v0, v1, v2, v3, ovf_re, ovf_im;
  mode_e m0, m1;
  logic [W-1:0] ra0, ia0, rb0, ib0, re_s, im_s;
  logic signed [P-1:0] p_rr, p_ii, p_ri, p_ir, re2, im2;
  logic [2*W-1:0] out_q;
  logic [1:0] ovf_q;
  function automatic logic signed [P-1:0] ext(input logic [W-1:0] x);
    return {{(P-W){SIGNED != 0 && x[W-1]}}, x};
  endfunction
  // A blocked result freezes the whole pipe; no bubble squeezing
  assign en = ~(v3 & ~bus.out_ready);
  assign bus.in_ready = rdy & en;
  assign acc = bus.in_valid & bus.in_ready;
  assign bus.out_valid = v3;
  assign bus.out = out_q;
  assign bus.out_ovf = ovf_q;
  cmult_round_sat #(.W(W), .FRAC(FRAC), .SIGNED(SIGNED), .ROUND(ROUND), .SAT(SAT)) u_re (
    .full(re2), .val(re_s), .ovf(ovf_re)
  );
  cmult_round_sat #(.W(W), .FRAC(FRAC), .SIGNED(SIGNED), .ROUND(ROUND), .SAT(SAT)) u_im (
    .full(im2), .val(im_s), .ovf(ovf_im)
  );
  // Operands are registered on accept so the multipliers start from flops
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rdy <= 1'b0;
      {v0, v1, v2, v3} <= '0;
      m0 <= REAL_PAIR;
      m1 <= REAL_PAIR;
      {ra0, ia0, rb0, ib0} <= '0;
      {p_rr, p_ii, p_ri, p_ir} <= '0;
      {re2, im2} <= '0;
      out_q <= '0;
      ovf_q <= '0;
    end else begin
      rdy <= 1'b1;
      if (en) begin
        v0 <= acc;
        v1 <= v0;
        v2 <= v1;
        v3 <= v2;
        if (acc) begin
          m0 <= mode_e'(bus.in_complex);
          ra0 <= bus.real_a;
          ia0 <= bus.im_a;
          rb0 <= bus.real_b;
          ib0 <= bus.im_b;
        end
        if (v0) begin
          m1 <= m0;
          p_rr <= ext(ra0) * ext(rb0);
          p_ii <= ext(ia0) * ext(ib0);
          p_ri <= ext(ra0) * ext(ib0);
          p_ir <= ext(ia0) * ext(rb0);
        end
        if (v1) begin
          re2 <= m1 == COMPLEX ? p_rr - p_ii : p_rr;
          im2 <= m1 == COMPLEX ? p_ri + p_ir : p_ii;
        end
        if (v2) begin
          out_q <= {re_s, im_s};
          ovf_q <= {ovf_re, ovf_im};
        end
      end
    end
endmodule

// File: tb/tb_cmult_pipe.sv
// tb_cmult_pipe: directed checks of cmult_pipe in Q15 signed/saturating and 32-bit unsigned configurations
module tb_cmult_pipe;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  cmult_pipe_if #(.W(16)) b16 ();
  cmult_pipe_if #(.W(32)) bw ();
  cmult_pipe_if #(.W(32)) bs ();
  cmult_pipe #(.W(16), .FRAC(15), .SIGNED(1), .ROUND(1), .SAT(1)) d16 (
    .clock(clock), .reset_n(reset_n), .bus(b16)
  );
  cmult_pipe d_w (.clock(clock), .reset_n(reset_n), .bus(bw));
  cmult_pipe #(.SAT(1)) d_s (.clock(clock), .reset_n(reset_n), .bus(bs));
  // Q15 vectors: mode, operands, expected {re, im} and {re_ovf, im_ovf}
  bit [0:7] t_c = 8'b10101010;
  logic [15:0] t_ra [8] = '{16'h4000, 16'h4000, 16'h2000, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 16'h0001};
  logic [15:0] t_ia [8] = '{16'h2000, 16'hC000, 16'h2000, 16'h1000, 16'h0000, 16'h2000, 16'h4000, 16'h0001};
  logic [15:0] t_rb [8] = '{16'h4000, 16'h2000, 16'h2000, 16'h4000, 16'h8000, 16'h4000, 16'h0000, 16'h0001};
  logic [15:0] t_ib [8] = '{16'h0000, 16'h4000, 16'h2000, 16'h8000, 16'h0000, 16'hE000, 16'h4000, 16'h4000};
  logic [31:0] t_out [8] = '{32'h2000_1000, 32'h1000_E000, 32'h0000_1000, 32'hC000_F000,
                             32'h7FFF_0000, 32'h2000_F800, 32'hE000_0000, 32'h0000_0001};
  logic [1:0] t_ovf [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};

  task automatic drive16(input logic v, input logic c, input logic [15:0] ra, ia, rb, ib);
    b16.in_valid = v;
    b16.in_complex = c;
    b16.real_a = ra;
    b16.im_a = ia;
    b16.real_b = rb;
    b16.im_b = ib;
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", b16.out_valid); end
    n_chk++; if (b16.out !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h want 0", b16.out); end
    n_chk++; if (b16.out_ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf got %b want 00", b16.out_ovf); end
    n_chk++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", b16.in_ready); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_chk++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", b16.in_ready); end
  endtask

  task automatic test_complex;
    int lat;
    @(negedge clock);
    drive16(1'b1, 1'b1, 16'h4000, 16'h4000, 16'h4000, 16'hC000);
    @(negedge clock);
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    lat = 0;
    while (b16.out_valid !== 1'b1 && lat < 8) begin @(negedge clock); lat++; end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL complex_latency got %0d want 3", lat); end
    n_chk++; if (b16.out !== 32'h4000_0000) begin n_fail++; $display("FAIL complex_out got %h want 40000000", b16.out); end
    n_chk++; if (b16.out_ovf !== 2'b00) begin n_fail++; $display("FAIL complex_ovf got %b want 00", b16.out_ovf); end
    @(negedge clock);
    n_chk++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL complex_drain got %b want 0", b16.out_valid); end
  endtask

  task automatic test_real_pair;
    int lat;
    @(negedge clock);
    drive16(1'b1, 1'b0, 16'h8000, 16'h4000, 16'h8000, 16'h4000);
    @(negedge clock);
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    lat = 0;
    while (b16.out_valid !== 1'b1 && lat < 8) begin @(negedge clock); lat++; end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL real_latency got %0d want 3", lat); end
    n_chk++; if (b16.out !== 32'h7FFF_2000) begin n_fail++; $display("FAIL real_out got %h want 7fff2000", b16.out); end
    n_chk++; if (b16.out_ovf !== 2'b10) begin n_fail++; $display("FAIL real_ovf got %b want 10", b16.out_ovf); end
  endtask

  task automatic test_wrap;
    int lat;
    @(negedge clock);
    bw.in_valid = 1'b1; bw.in_complex = 1'b1;
    bw.real_a = 32'h0; bw.im_a = 32'h8000_0000; bw.real_b = 32'h0; bw.im_b = 32'h8000_0000;
    bs.in_valid = 1'b1; bs.in_complex = 1'b1;
    bs.real_a = 32'h0; bs.im_a = 32'h8000_0000; bs.real_b = 32'h0; bs.im_b = 32'h8000_0000;
    @(negedge clock);
    bw.in_valid = 1'b0;
    bs.in_valid = 1'b0;
    lat = 0;
    while (bw.out_valid !== 1'b1 && lat < 8) begin @(negedge clock); lat++; end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL wrap_latency got %0d want 3", lat); end
    n_chk++; if (bw.out !== 64'hC000_0000_0000_0000) begin n_fail++; $display("FAIL wrap_out got %h want c000000000000000", bw.out); end
    n_chk++; if (bw.out_ovf !== 2'b10) begin n_fail++; $display("FAIL wrap_ovf got %b want 10", bw.out_ovf); end
    n_chk++; if (bs.out_valid !== 1'b1 || bs.out !== 64'h0) begin n_fail++; $display("FAIL clamp_out got v=%b %h want v=1 0", bs.out_valid, bs.out); end
    n_chk++; if (bs.out_ovf !== 2'b10) begin n_fail++; $display("FAIL clamp_ovf got %b want 10", bs.out_ovf); end
  endtask

  task automatic test_stream_stall;
    int pi = 0;
    int ri = 0;
    int cyc = 0;
    while (ri < 8 && cyc < 60) begin
      @(negedge clock); #1;
      b16.out_ready = !(cyc >= 6 && cyc < 11);
      if (pi < 8) drive16(1'b1, t_c[pi], t_ra[pi], t_ia[pi], t_rb[pi], t_ib[pi]);
      else drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      #1;
      if (b16.out_valid === 1'b1) begin
        n_chk++;
        if (b16.out !== t_out[ri] || b16.out_ovf !== t_ovf[ri]) begin
          n_fail++;
          $display("FAIL stream_result[%0d] got %h/%b want %h/%b", ri, b16.out, b16.out_ovf, t_out[ri], t_ovf[ri]);
        end
        if (b16.out_ready) ri++;
      end
      if (!b16.out_ready) begin
        n_chk++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, b16.in_ready); end
      end
      if (b16.in_valid && b16.in_ready) pi++;
      cyc++;
    end
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    b16.out_ready = 1'b1;
    n_chk++; if (ri != 8) begin n_fail++; $display("FAIL stream_count got %0d want 8", ri); end
    @(negedge clock); #2;
    n_chk++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_tail got %b want 0", b16.out_valid); end
  endtask

  task automatic test_reset_mid;
    int lat;
    b16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive16(1'b1, t_c[i], t_ra[i], t_ia[i], t_rb[i], t_ib[i]);
    end
    @(negedge clock);
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    n_chk++; if (b16.out_valid !== 1'b1 || b16.out !== t_out[0]) begin n_fail++; $display("FAIL mid_pre got v=%b %h want v=1 %h", b16.out_valid, b16.out, t_out[0]); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drop got %b want 0", b16.out_valid); end
    n_chk++; if (b16.out !== 32'h0 || b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_clear got %h rdy=%b want 0 rdy=0", b16.out, b16.in_ready); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_chk++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc %0d got %b want 0", i, b16.out_valid); end
    end
    drive16(1'b1, t_c[7], t_ra[7], t_ia[7], t_rb[7], t_ib[7]);
    #1;
    n_chk++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", b16.in_ready); end
    @(negedge clock);
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    lat = 0;
    while (b16.out_valid !== 1'b1 && lat < 8) begin @(negedge clock); lat++; end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL mid_latency got %0d want 3", lat); end
    n_chk++; if (b16.out !== t_out[7] || b16.out_ovf !== t_ovf[7]) begin n_fail++; $display("FAIL mid_result got %h/%b want %h/%b", b16.out, b16.out_ovf, t_out[7], t_ovf[7]); end
  endtask

  initial begin
    drive16(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    b16.out_ready = 1'b1;
    bw.in_valid = 1'b0; bw.in_complex = 1'b0; bw.out_ready = 1'b1;
    bw.real_a = '0; bw.im_a = '0; bw.real_b = '0; bw.im_b = '0;
    bs.in_valid = 1'b0; bs.in_complex = 1'b0; bs.out_ready = 1'b1;
    bs.real_a = '0; bs.im_a = '0; bs.real_b = '0; bs.im_b = '0;
    test_reset;
    test_complex;
    test_real_pair;
    test_wrap;
    test_stream_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1);
  end
endmodule

// File: doc/cmult_pipe.md
# cmult_pipe

Parametrised, fully pipelined complex/real-pair multiplier with valid/ready handshakes on both sides, per-transaction mode, configurable fixed-point output scaling, rounding and saturation. It is the next generation of the datapath's multiplier. It sits between the sample source and the accumulation/FFT stages and accepts one operation per cycle when not back-pressured.

## Interface
- `W`, 32: operand width per real/imag component.
- `FRAC`, 32: right-shift applied to full-precision results (fraction bits dropped); legal 1..2W-1.
- `SIGNED`, 0: 1 = two's-complement operands, 0 = unsigned.
- `ROUND`, 0: 1 = round-half-up before shift, 0 = truncate.
- `SAT`, 0: 1 = saturate to W bits, 0 = keep low W bits (wrap).
- `clock  in  1`: single clock, rising edge.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `in_valid  in  1`: input operation present.
- `in_ready  out  1`: block accepts input this cycle.
- `in_complex  in  1`: 1 = complex multiply, 0 = two independent real multiplies; travels with the data.
- `real_a`, `im_a`, `real_b`, `im_b`  in  W each: operands.
- `out_valid  out  1`: result present.
- `out_ready  in  1`: downstream accepts result.
- `out  out  2W`: {re, im} result.
- `out_ovf  out  2`: {re_ovf, im_ovf}; set when saturation clamped (SAT=1) or wrap discarded significant bits (SAT=0).

## Operation
- Complex: re = ra·rb − ia·ib, im = ra·ib + ia·rb, computed at full precision (2W+2 bits signed internally), then scaled.
- Real-pair: re = ra·rb, im = ia·ib; the other two products are ignored.
- Scaling per component: if ROUND, add 2^(FRAC−1); arithmetic shift right by FRAC; then fit to W bits.
- Saturation limits: SIGNED=1 → [−2^(W−1), 2^(W−1)−1]; SIGNED=0 → [0, 2^W−1]. Negative unsigned complex results clamp to 0 (SAT=1) or wrap (SAT=0); either way the ovf bit is set.
- Mode is captured per transaction; mixing complex and real-pair operations back-to-back is legal, and each result uses its own mode.
- Stages: S1 registers the four products and the mode; S2 registers the add/sub sums; S3 registers the rounded/saturated output and ovf.
- Each stage has a valid bit; no state machine beyond the stage valids.

## Timing
- Reset (async assert, sync release): all stage valids 0, `out_valid`=0, `out`=0, `out_ovf`=0. `in_ready` is 1 from the first edge after release.
- Latency: input accepted at edge N → `out_valid` high after edge N+3.
- Throughput: 1 op/cycle while `out_ready`=1.
- Stall = `out_valid` & ~`out_ready`. While stalled, all stages hold, `in_ready`=0, and `out`/`out_ovf` stay stable.
- Empty pipeline: bubbles propagate; `out_valid` falls the cycle after the last result handshakes with no successor.
- `in_valid` while `in_ready`=0: ignored, not captured.
- Simultaneous output handshake and input accept: both occur; no loss, no duplicate.
- Reset mid-operation: all in-flight results are discarded; no `out_valid` until new inputs traverse the 3 stages.

## Structure
- Package `cmult_pkg`: mode constants (COMPLEX=1, REAL_PAIR=0), saturation-limit functions of W/SIGNED, and the round/shift helper.
- Sub-module `cmult_round_sat`: one full-precision component → W-bit value + ovf; instantiated twice (re, im) in S3.
- Products are inferred multipliers in S1; no multi-cycle multiplier.

## Test plan
- W=16, FRAC=15, SIGNED=1, ROUND=1, SAT=1, complex (16384+16384j)·(16384−16384j) → out re=16384, im=0, ovf=00, 3 cycles after accept.
- Same params, real-pair, ra=rb=−32768, ia=ib=16384 → re=32767, re_ovf=1; im=8192, im_ovf=0.
- Defaults (W=32, FRAC=32, unsigned), complex, ra=ib=0, ia=ib... specifically ra=0, ia=1·2^31, rb=0, ib=2^31 → re wraps (negative), re_ovf=1; with SAT=1, re=0.
- Stream 8 alternating complex/real-pair ops; hold `out_ready`=0 for 5 cycles mid-stream → `in_ready` low, outputs frozen, all 8 results arrive in order, each matching its own mode.
- Assert `reset_n`=0 with 3 ops in flight → `out_valid` drops immediately, no stale result after release; the first new op appears exactly 3 cycles after acceptance.
